// File: rtl/counter_pkg.sv
// Shared types and default widths for the up-counter and countdown timer paths.
package counter_pkg;

    localparam int unsigned OutputWidthDefault  = 6;
    localparam int unsigned DivisionBitsDefault = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } timer_state_t;

endpackage

// File: rtl/prescaler_nbit.sv
// Free-running prescaler: tick is high while the count is all-ones, or always when
// DIVISIONBITS is 0. clear takes precedence over enable.
module prescaler_nbit
    import counter_pkg::*;
#(
    parameter int unsigned DIVISIONBITS = DivisionBitsDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    if (DIVISIONBITS == 0) begin : g_bypass
        logic unused_inputs;
        assign unused_inputs = ^{clk, reset, clear, enable};
        assign tick = 1'b1;
    end else begin : g_count
        logic [DIVISIONBITS-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clear) begin
                cnt_d = '0;
            end else if (enable) begin
                cnt_d = cnt_q + DIVISIONBITS'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign tick = &cnt_q;
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable, pausable down-counter with prescaler and one-cycle done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload and keep running on reaching zero.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int unsigned OUTPUTWIDTH  = OutputWidthDefault,
    parameter int unsigned DIVISIONBITS = DivisionBitsDefault
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [OUTPUTWIDTH-1:0] load_value,
    input  logic                   start,
    input  logic                   pause,
    output logic [OUTPUTWIDTH-1:0] value,
    output logic                   running,
    output logic                   done
);

    timer_state_t           state_q, state_d;
    logic [OUTPUTWIDTH-1:0] value_q, value_d;
    logic [OUTPUTWIDTH-1:0] reload_q, reload_d;
    logic                   running_q, running_d;
    logic                   done_q, done_d;
    logic                   presc_enable;
    logic                   presc_tick;

    // The prescaler only advances on cycles that could actually decrement, so a
    // pause or load freezes or clears its phase on the same edge.
    assign presc_enable = !load && (state_q == RUN) && !pause;

    prescaler_nbit #(
        .DIVISIONBITS (DIVISIONBITS)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (load),
        .enable (presc_enable),
        .tick   (presc_tick)
    );

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            value_d  = load_value;
            reload_d = load_value;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && (value_q != '0)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (presc_tick) begin
                        if (value_q == OUTPUTWIDTH'(1)) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (reload_q != '0) begin
                                value_d = reload_q;
                            end else begin
                                value_d = '0;
                                state_d = DONE;
                            end
`else
                            value_d = '0;
                            state_d = DONE;
`endif
                        end else begin
                            value_d = value_q - OUTPUTWIDTH'(1);
                        end
                    end
                end
                PAUSED: begin
                    if (start && !pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            value_q   <= '0;
            reload_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            reload_q  <= reload_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    logic unused_reload;
    assign unused_reload = ^reload_q;
`endif

    assign value   = value_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Drives two timers (prescaler widths 0 and 2) with shared stimulus and scores them
// against a cycle-level reference model through an expectation queue.
module tb_countdown_timer;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;

    logic [W-1:0] value_a, value_b;
    logic         running_a, running_b;
    logic         done_a, done_b;

    always #5 clk = ~clk;

    countdown_timer #(
        .OUTPUTWIDTH  (W),
        .DIVISIONBITS (0)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .value      (value_a),
        .running    (running_a),
        .done       (done_a)
    );

    countdown_timer #(
        .OUTPUTWIDTH  (W),
        .DIVISIONBITS (2)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .value      (value_b),
        .running    (running_b),
        .done       (done_b)
    );

    typedef struct {
        int dut;
        int value;
        int running;
        int done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   started  = 0;

    // Reference model: mode 0 idle, 1 counting, 2 paused, 3 finished.
    int m_cnt[2]    = '{0, 0};
    int m_rel[2]    = '{0, 0};
    int m_elapsed[2] = '{0, 0};
    int m_mode[2]   = '{0, 0};
    int m_period[2] = '{1, 4};

    task automatic model_step(input int k, input bit r, input bit l, input int lv,
                              input bit s, input bit p);
        exp_t e;
        int   d;
        d = 0;
        if (r) begin
            m_cnt[k] = 0; m_rel[k] = 0; m_elapsed[k] = 0; m_mode[k] = 0;
        end else if (l) begin
            m_cnt[k] = lv; m_rel[k] = lv; m_elapsed[k] = 0; m_mode[k] = 0;
        end else begin
            case (m_mode[k])
                0: if (s && m_cnt[k] != 0) m_mode[k] = 1;
                1: begin
                    if (p) begin
                        m_mode[k] = 2;
                    end else begin
                        m_elapsed[k] = m_elapsed[k] + 1;
                        if (m_elapsed[k] == m_period[k]) begin
                            m_elapsed[k] = 0;
                            if (m_cnt[k] == 1) begin
                                d = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                                if (m_rel[k] != 0) begin
                                    m_cnt[k] = m_rel[k];
                                end else begin
                                    m_cnt[k] = 0; m_mode[k] = 3;
                                end
`else
                                m_cnt[k] = 0; m_mode[k] = 3;
`endif
                            end else begin
                                m_cnt[k] = m_cnt[k] - 1;
                            end
                        end
                    end
                end
                2: if (s && !p) m_mode[k] = 1;
                default: ;
            endcase
        end
        e.dut = k;
        e.value = m_cnt[k];
        e.running = (m_mode[k] == 1) ? 1 : 0;
        e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit l, input int lv, input bit s, input bit p);
        @(negedge clk);
        reset = r;
        load = l;
        load_value = W'(lv);
        start = s;
        pause = p;
        for (int k = 0; k < 2; k++) model_step(k, r, l, lv % 64, s, p);
        started = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    // Monitor: every DUT output is valid each cycle, so pop one entry per DUT per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                for (int i = 0; i < 2; i++) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL scoreboard_underflow: got empty queue, expected entry");
                    end else begin
                        e = exp_q.pop_front();
                        if (e.dut == 0) begin
                            check("a.value", int'(value_a), e.value);
                            check("a.running", int'(running_a), e.running);
                            check("a.done", int'(done_a), e.done);
                        end else begin
                            check("b.value", int'(value_b), e.value);
                            check("b.running", int'(running_b), e.running);
                            check("b.done", int'(done_b), e.done);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int lv;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // Basic countdown, then start while finished.
        drive(0, 1, 5, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(24);
        drive(0, 0, 0, 1, 0);
        idle(3);
        // Start with zero loaded, and load with start in the same cycle.
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(3);
        drive(0, 1, 7, 1, 0);
        idle(2);
        // Pause and resume, including pause with start together.
        drive(0, 1, 10, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(6);
        drive(0, 0, 0, 0, 1);
        idle(20);
        drive(0, 0, 0, 1, 0);
        idle(9);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 1);
        idle(3);
        drive(0, 0, 0, 1, 0);
        idle(50);
        // Load during a count, then reset mid-count.
        drive(0, 1, 20, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(8);
        drive(0, 1, 7, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(5);
        drive(1, 0, 0, 0, 0);
        idle(3);
        // Largest load value.
        drive(0, 1, 63, 0, 0);
        drive(0, 0, 0, 1, 0);
        idle(70);
        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            lv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                             : int'($urandom_range(0, 8));
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0), lv,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0));
        end
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
